// File: rtl/pcfx_bk_sd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pcfx_bk_sd_pkg                                                     |
// | Shared types for the PC-FX backup-RAM sector mover.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pcfx_bk_sd_pkg;

  localparam int BK_SECT_WORDS = 256;

  typedef enum logic [1:0] {
    BK_IDLE = 2'd0,
    BK_REQ  = 2'd1,
    BK_XFER = 2'd2,
    BK_NEXT = 2'd3
  } bk_state_t;

  typedef struct packed {
    logic [8:0] nsect;
    logic       ro;
    logic       valid;
  } bk_drive_t;

  // Image size is already in sectors (bytes >> 9); clip to the RAM capacity.
  function automatic logic [8:0] bk_clip_sect(input logic [54:0] size_sect,
                                              input logic [8:0]  max_sect);
    return (size_sect > {46'd0, max_sect}) ? max_sect : size_sect[8:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcfx_bk_sd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pcfx_bk_sd                                                         |
// | Moves 512-byte sectors between SAV/FXB images and backup RAM.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pcfx_bk_sd
  import pcfx_bk_sd_pkg::*;
#(
  parameter int INT_SECT = 64,
  parameter int EXT_SECT = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        bk_load,
  input  logic        bk_save,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic [1:0]  sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic        ram_sel,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic        bk_ena,
  output logic        busy
);

  bk_state_t  r_state, w_state_nx;
  bk_drive_t  r_drive [2];
  logic [1:0] r_pend_load, r_pend_save;
  logic       r_load_q, r_save_q;
  logic       r_drv, r_dir;
  logic       r_abort;
  logic [8:0] r_sector;

  logic [8:0] w_new_nsect [2];
  logic [1:0] w_new_valid, w_valid_nx, w_ro_nx;
  logic       w_load_rise, w_save_rise;
  logic       w_grant, w_gdrv, w_gdir, w_start;
  logic [1:0] w_gmask, w_clr_load, w_clr_save;
  logic       w_ack, w_last, w_drop;
  logic [8:0] w_sector_inc;
  logic       w_unused_size;

  assign w_unused_size = ^img_size[8:0];

  for (genvar d = 0; d < 2; d++) begin : g_drive
    localparam logic [8:0] C_MAX = (d == 0) ? 9'(INT_SECT) : 9'(EXT_SECT);
    assign w_new_nsect[d] = bk_clip_sect(img_size[63:9], C_MAX);
    assign w_new_valid[d] = (w_new_nsect[d] != 9'd0);
    assign w_valid_nx[d]  = img_mounted[d] ? w_new_valid[d] : r_drive[d].valid;
    assign w_ro_nx[d]     = img_mounted[d] ? img_readonly   : r_drive[d].ro;
  end

  assign w_load_rise  = bk_load & ~r_load_q;
  assign w_save_rise  = bk_save & ~r_save_q;
  assign w_ack        = sd_ack[r_drv];
  assign w_sector_inc = r_sector + 9'd1;
  assign w_last       = (w_sector_inc >= r_drive[r_drv].nsect);
  // A remount of the drive being transferred ends the job at the sector boundary.
  assign w_drop       = r_abort | img_mounted[r_drv];

  always_comb begin
    w_grant = 1'b1;
    w_gdrv  = 1'b0;
    w_gdir  = 1'b0;
    if (r_pend_load[0]) begin
      w_gdrv = 1'b0;
    end else if (r_pend_load[1]) begin
      w_gdrv = 1'b1;
    end else if (r_pend_save[0]) begin
      w_gdir = 1'b1;
    end else if (r_pend_save[1]) begin
      w_gdrv = 1'b1;
      w_gdir = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_start    = (r_state == BK_IDLE) & w_grant;
  assign w_gmask    = w_gdrv ? 2'b10 : 2'b01;
  assign w_clr_load = (w_start & ~w_gdir) ? w_gmask : 2'b00;
  assign w_clr_save = (w_start &  w_gdir) ? w_gmask : 2'b00;

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= BK_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    sd_rd      = 2'b00;
    sd_wr      = 2'b00;
    ram_we     = 1'b0;
    case (r_state)
      BK_IDLE: if (w_grant) w_state_nx = BK_REQ;
      BK_REQ: begin
        // Request is withdrawn combinationally as soon as ack rises.
        if (!w_ack) begin
          if (r_dir) sd_wr = r_drv ? 2'b10 : 2'b01;
          else       sd_rd = r_drv ? 2'b10 : 2'b01;
        end else begin
          w_state_nx = BK_XFER;
        end
      end
      BK_XFER: begin
        ram_we = ~r_dir & sd_buff_wr & w_ack & ~r_abort &
                 (r_sector < r_drive[r_drv].nsect);
        if (!w_ack) w_state_nx = BK_NEXT;
      end
      BK_NEXT: w_state_nx = (w_last || w_drop) ? BK_IDLE : BK_REQ;
      default: w_state_nx = BK_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) r_drive[d] <= '0;
      r_pend_load <= 2'b00;
      r_pend_save <= 2'b00;
      r_load_q    <= 1'b0;
      r_save_q    <= 1'b0;
      r_drv       <= 1'b0;
      r_dir       <= 1'b0;
      r_abort     <= 1'b0;
      r_sector    <= 9'd0;
    end else begin
      r_load_q <= bk_load;
      r_save_q <= bk_save;
      for (int d = 0; d < 2; d++) begin
        if (img_mounted[d]) begin
          r_drive[d].nsect <= w_new_nsect[d];
          r_drive[d].ro    <= img_readonly;
          r_drive[d].valid <= w_new_valid[d];
        end
      end
      r_pend_load <= ((r_pend_load & ~w_clr_load) | (img_mounted & w_new_valid) |
                      ({2{w_load_rise}} & w_valid_nx)) & w_valid_nx;
      r_pend_save <= ((r_pend_save & ~w_clr_save) |
                      ({2{w_save_rise}} & w_valid_nx & ~w_ro_nx)) & w_valid_nx & ~w_ro_nx;
      if (w_start) begin
        r_drv    <= w_gdrv;
        r_dir    <= w_gdir;
        r_sector <= 9'd0;
        r_abort  <= img_mounted[w_gdrv];
      end else if (r_state != BK_IDLE && img_mounted[r_drv]) begin
        r_abort <= 1'b1;
      end
      if (r_state == BK_NEXT) r_sector <= w_sector_inc;
    end
  end

  assign sd_lba      = {23'd0, r_sector};
  assign sd_buff_din = ram_rdata;
  assign ram_sel     = r_drv;
  assign ram_addr    = {r_sector[7:0], sd_buff_addr};
  assign ram_wdata   = sd_buff_dout;
  assign bk_ena      = r_drive[0].valid;
  assign busy        = (r_state != BK_IDLE);

endmodule
`default_nettype wire
